// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the ADC sample framer.
package adc_pkg;

  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int ADC_OFFSET = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_WAIT
  } adc_state_e;

  // Offset-binary ADC code to a signed value centred on mid-scale.
  function automatic logic signed [ADC_BITS:0] adc_center(input logic [ADC_BITS-1:0] raw);
    logic signed [ADC_BITS:0] ext;
    ext = $signed({1'b0, raw});
    return ext - ADC_OFFSET[ADC_BITS:0];
  endfunction

endpackage

// File: rtl/adc_sample_framer_tick_gen.sv
// Free-running sample-period counter; Tick marks count 0 while En is high.
module tick_gen #(
  parameter int SAMPLE_DIV = 5000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic En,
  output logic Tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (En && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign Tick = En && (cnt_q == '0);

endmodule

// File: rtl/adc_sample_framer.sv
// Periodic serial ADC reader producing a scaled signed sample and Enable strobe.
// Optional rail flag output Clip when ADC_CLIP_FLAG_EN is defined.
//
// state    | meaning
// IDLE     | Start low or waiting for the first tick after Start rises
// CS_SETUP | CS_n low, SCLK low for CLK_DIV cycles before the first bit
// SHIFT    | 16 SCLK periods, SDATA captured on each SCLK rise
// DONE     | CS_n high, u registered, Enable high for this one cycle
// WAIT     | between frames, next tick starts CS_SETUP
module adc_sample_framer
  import adc_pkg::*;
#(
  parameter int W          = 25,
  parameter int FRAC       = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic                SDATA,
  output logic                SCLK,
  output logic                CS_n,
  output logic signed [W-1:0] u,
  output logic                Enable,
  output logic                Busy
`ifdef ADC_CLIP_FLAG_EN
  ,
  output logic                Clip
`endif
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("adc_sample_framer: CLK_DIV must be at least 1");
  end
  if ((FRAC < ADC_BITS - 1) || (FRAC > W - 2)) begin : g_bad_frac
    $error("adc_sample_framer: FRAC must lie in 11..W-2");
  end
  if (SAMPLE_DIV < 33 * CLK_DIV + 2) begin : g_bad_sample_div
    $error("adc_sample_framer: SAMPLE_DIV too small, frames would overlap ticks");
  end

  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW        = $clog2(FRAME_BITS);
  localparam int SHIFT_AMT = FRAC - (ADC_BITS - 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(FRAME_BITS - 1);

  adc_state_e                state_q, state_d;
  logic [DW-1:0]             div_q, div_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
  logic                      sclk_q, sclk_d;
  logic                      cs_n_q, cs_n_d;
  logic signed [W-1:0]       u_q, u_d;
  logic                      en_q, en_d;
  logic                      busy_q, busy_d;
  logic                      tick;
  logic [ADC_BITS-1:0]       raw;
  logic signed [ADC_BITS:0]  centered;
  logic signed [W-1:0]       scaled;
  logic                      unused_hdr;

  tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .CLK  (CLK),
    .Reset(Reset),
    .En   (Start),
    .Tick (tick)
  );

  // The four leading header bits of the frame carry no sample information.
  assign raw        = shreg_q[ADC_BITS-1:0];
  assign unused_hdr = ^shreg_q[FRAME_BITS-1:ADC_BITS];
  assign centered   = adc_center(raw);
  assign scaled     = W'(centered) <<< SHIFT_AMT;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    u_d     = u_q;
    sclk_d  = 1'b0;
    cs_n_d  = 1'b1;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (tick) begin
          state_d = ST_CS_SETUP;
          div_d   = DIV_LOAD;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (!Start) begin
          state_d = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        if (div_q == '0) begin
          state_d = ST_SHIFT;
          div_d   = DIV_LOAD;
          bit_d   = BIT_LOAD;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        sclk_d = sclk_q;
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_LOAD;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], SDATA};
          end else if (bit_q != '0) begin
            sclk_d = 1'b0;
            bit_d  = bit_q - 1'b1;
          end else begin
            state_d = ST_DONE;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            en_d    = 1'b1;
            u_d     = scaled;
          end
        end
      end
      ST_DONE: begin
        state_d = Start ? ST_WAIT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      u_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      u_q     <= u_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign SCLK   = sclk_q;
  assign CS_n   = cs_n_q;
  assign u      = u_q;
  assign Enable = en_q;
  assign Busy   = busy_q;

`ifdef ADC_CLIP_FLAG_EN
  logic clip_q;
  logic raw_rail;

  assign raw_rail = (raw == '0) || (raw == '1);

  // Updated on the same edge as u so it is valid alongside Enable.
  always_ff @(posedge CLK) begin
    if (!Reset)    clip_q <= 1'b0;
    else if (en_d) clip_q <= raw_rail;
  end

  assign Clip = clip_q;
`else
  // Without the rail flag the sample path is unchanged.
`endif

endmodule

// File: tb/tb_adc_sample_framer.sv
// Scoreboard bench for adc_sample_framer: ADC model pushes expected samples, monitor checks them.
// Also checks Clip when built with ADC_CLIP_FLAG_EN.
module tb_adc_sample_framer;

  localparam int W          = 25;
  localparam int FRAC       = 16;
  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_DIV = 100;
  localparam int LAT        = 33 * CLK_DIV + 1;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic SDATA = 1'b0;
  logic SCLK, CS_n, Enable, Busy;
  logic signed [W-1:0] u;
`ifdef ADC_CLIP_FLAG_EN
  logic Clip;
`endif

  adc_sample_framer #(
    .W(W), .FRAC(FRAC), .CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .Start (Start),
    .SDATA (SDATA),
    .SCLK  (SCLK),
    .CS_n  (CS_n),
    .u     (u),
    .Enable(Enable),
    .Busy  (Busy)
`ifdef ADC_CLIP_FLAG_EN
    ,
    .Clip  (Clip)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] u;
    logic         clip;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] force_q[$];
  int          en_times[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_falls = 0;
  int enables = 0;
  int sclk_rises = 0;
  int cs_fall_cyc = 0;
  bit abort_frame = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: centre the 12-bit code on 2048 and scale to FRAC fractional bits.
  function automatic exp_t ref_model(input logic [15:0] frame);
    int   raw;
    int   val;
    exp_t e;
    raw    = int'(frame & 16'h0FFF);
    val    = (raw - 2048) * (2 ** (FRAC - 11));
    e.u    = val[W-1:0];
    e.clip = (raw == 0) || (raw == 4095);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ADC model: present MSB when CS_n falls, next bit after each SCLK fall.
  initial begin : adc_model
    logic [15:0] word;
    int          idx;
    logic        cs_prev, sclk_prev;
    word = '0; idx = 0; cs_prev = 1'b1; sclk_prev = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (cs_prev && !CS_n) begin
        if (force_q.size() > 0) word = force_q.pop_front();
        else                    word = 16'($urandom);
        exp_q.push_back(ref_model(word));
        idx   = 15;
        SDATA = word[idx];
      end else if (!CS_n && sclk_prev && !SCLK && idx > 0) begin
        idx--;
        SDATA = word[idx];
      end else if (CS_n) begin
        SDATA = 1'($urandom);
      end
      cs_prev   = CS_n;
      sclk_prev = SCLK;
    end
  end

  initial begin : monitor
    logic cs_prev, sclk_prev, en_prev;
    exp_t e;
    cs_prev = 1'b1; sclk_prev = 1'b0; en_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (cs_prev && !CS_n) begin
        cs_falls++;
        cs_fall_cyc = cyc;
        sclk_rises  = 0;
        chk("busy_at_cs_fall", 64'(Busy), 64'd1);
      end
      if (!CS_n && !sclk_prev && SCLK) begin
        sclk_rises++;
        if (sclk_rises == 1) chk("first_sclk_rise", 64'(cyc - cs_fall_cyc), 64'(2 * CLK_DIV));
      end
      if (!cs_prev && CS_n) begin
        if (abort_frame) abort_frame = 1'b0;
        else             chk("sclk_rises_per_frame", 64'(sclk_rises), 64'd16);
      end
      if (Enable) begin
        enables++;
        en_times.push_back(cyc);
        chk("enable_one_cycle", 64'(en_prev), 64'd0);
        chk("enable_latency", 64'(cyc - cs_fall_cyc), 64'(LAT - 1));
        chk("cs_sclk_in_done", {62'd0, CS_n, SCLK}, 64'd2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_enable: got Enable with empty queue, want none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("u_value", 64'($unsigned(u)), 64'(e.u));
`ifdef ADC_CLIP_FLAG_EN
          chk("clip_flag", 64'(Clip), 64'(e.clip));
`endif
        end
      end
      cs_prev   = CS_n;
      sclk_prev = SCLK;
      en_prev   = Enable;
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int base;
    int idx0;
    int saved_cs;

    // Reset state
    step(3);
    chk("rst_cs_n", 64'(CS_n), 64'd1);
    chk("rst_sclk", 64'(SCLK), 64'd0);
    chk("rst_u", 64'($unsigned(u)), 64'd0);
    chk("rst_enable", 64'(Enable), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    Reset = 1'b1;
    step(2);

    // Mid-scale, both rails and near-rail codes, then random frames.
    force_q.push_back(16'h0800);
    force_q.push_back(16'h0FFF);
    force_q.push_back(16'h0000);
    force_q.push_back(16'h07FF);
    force_q.push_back(16'hA001);
    idx0  = en_times.size();
    base  = enables;
    Start = 1'b1;
    n = 0;
    do begin step(1); n++; end while (CS_n && n < 20);
    chk("start_to_cs", 64'(n), 64'd1);
    n = 0;
    while (enables < base + 8 && n < 1200) begin @(negedge CLK); n++; end
    chk("frames_done", 64'(enables - base), 64'd8);
    for (int i = idx0 + 1; i < idx0 + 8 && i < en_times.size(); i++)
      chk("enable_spacing", 64'(en_times[i] - en_times[i-1]), 64'(SAMPLE_DIV));

    // Drop Start mid-SHIFT: frame must finish, then CS_n stays idle.
    force_q.push_back(16'h0123);
    n = 0;
    do begin step(1); n++; end while (CS_n && n < 200);
    step(20);
    base  = enables;
    Start = 1'b0;
    n = 0;
    while (enables == base && n < 200) begin @(negedge CLK); n++; end
    chk("stop_frame_enable", 64'(enables - base), 64'd1);
    saved_cs = cs_falls;
    step(300);
    chk("no_cs_after_stop", 64'(cs_falls), 64'(saved_cs));
    chk("no_enable_after_stop", 64'(enables - base), 64'd1);
    chk("idle_cs_n", 64'(CS_n), 64'd1);

    // Reset during SHIFT bit 7.
    Start = 1'b1;
    n = 0;
    do begin step(1); n++; end while (CS_n && n < 200);
    step(35);
    abort_frame = 1'b1;
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    exp_q.delete();
    chk("mid_rst_cs_n", 64'(CS_n), 64'd1);
    chk("mid_rst_sclk", 64'(SCLK), 64'd0);
    chk("mid_rst_u", 64'($unsigned(u)), 64'd0);
    chk("mid_rst_enable", 64'(Enable), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    n = 0;
    do begin step(1); n++; end while (!Enable && n < 200);
    chk("reset_to_enable", 64'(n), 64'(LAT));

    // A few more random frames, then drain.
    base = enables;
    n = 0;
    while (enables < base + 3 && n < 500) begin @(negedge CLK); n++; end
    Start = 1'b0;
    n = 0;
    while ((exp_q.size() > 0 || Busy) && n < 300) begin @(negedge CLK); n++; end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
